// File: rtl/fixed_point.sv
// Q-format fixed-point word definitions shared across the vector_math datapath.
package fixed_point;

    localparam int WIDTH = 32;
    localparam int FRAC  = 16;

    typedef logic signed [WIDTH-1:0] fixed_point_t;

    localparam fixed_point_t FP_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam fixed_point_t FP_MIN = {1'b1, {(WIDTH-1){1'b0}}};

endpackage

// File: rtl/vector.sv
// Three-component fixed-point vector type and axis selector for component muxing.
package vector;

    typedef struct packed {
        fixed_point::fixed_point_t x;
        fixed_point::fixed_point_t y;
        fixed_point::fixed_point_t z;
    } vector_t;

    typedef enum logic [1:0] {
        AXIS_X,
        AXIS_Y,
        AXIS_Z
    } axis_t;

    function automatic fixed_point::fixed_point_t get_axis(input vector_t v, input axis_t a);
        case (a)
            AXIS_Y:  return v.y;
            AXIS_Z:  return v.z;
            default: return v.x;
        endcase
    endfunction

endpackage

// File: rtl/vector_dot_seq_pkg.sv
// FSM encoding for vector_dot_seq and the mapping from state to multiplier axis.
package vector_dot_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL_X,
        MUL_Y,
        MUL_Z,
        DONE
    } state_t;

    // Only the MUL_* states drive the multiplier; other states default to X harmlessly.
    function automatic vector::axis_t state_axis(input state_t s);
        case (s)
            MUL_Y:   return vector::AXIS_Y;
            MUL_Z:   return vector::AXIS_Z;
            default: return vector::AXIS_X;
        endcase
    endfunction

endpackage

// File: rtl/fixed_point_mul.sv
// Combinational signed WIDTH x WIDTH multiply returning the exact 2*WIDTH-bit product.
module fixed_point_mul #(
    parameter int WIDTH = fixed_point::WIDTH
) (
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] product
);

    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;

    // Sign-extend explicitly so the low 2*WIDTH bits are the exact signed product.
    assign a_ext   = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext   = {{WIDTH{b[WIDTH-1]}}, b};
    assign product = a_ext * b_ext;

endmodule

// File: rtl/vector_dot_seq.sv
// Sequential fixed-point dot product using one shared multiplier over three cycles.
// Build option VECTOR_DOT_SAT_EN: clamp result on overflow instead of wrapping.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// MUL_X | accumulate x1*x2 term
// MUL_Y | accumulate y1*y2 term
// MUL_Z | accumulate z1*z2 term, register result and overflow
// DONE  | out_valid high, hold result until out_ready
module vector_dot_seq
    import vector_dot_seq_pkg::*;
#(
    parameter int WIDTH = fixed_point::WIDTH,
    parameter int FRAC  = fixed_point::FRAC,
    parameter int GUARD = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  vector::vector_t           op1,
    input  vector::vector_t           op2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output fixed_point::fixed_point_t result,
    output logic                      overflow
);

    localparam int PROD_W = 2 * WIDTH;
    localparam int ACC_W  = 2 * WIDTH - FRAC + GUARD;

    state_t                    state;
    vector::vector_t           op1_q;
    vector::vector_t           op2_q;
    logic signed [ACC_W-1:0]   acc;

    vector::axis_t             sel;
    logic signed [WIDTH-1:0]   mul_a;
    logic signed [WIDTH-1:0]   mul_b;
    logic signed [PROD_W-1:0]  product;
    logic signed [ACC_W-1:0]   term_ext;
    logic signed [ACC_W-1:0]   acc_sum;
    logic [ACC_W-WIDTH:0]      sum_upper;
    logic                      sum_ovf;
    logic [WIDTH-1:0]          sum_res;

    assign sel   = state_axis(state);
    assign mul_a = vector::get_axis(op1_q, sel);
    assign mul_b = vector::get_axis(op2_q, sel);

    fixed_point_mul #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .a       (mul_a),
        .b       (mul_b),
        .product (product)
    );

    // Arithmetic shift floors the term; GUARD bits keep three terms from wrapping.
    assign term_ext = ACC_W'(product >>> FRAC);
    assign acc_sum  = acc + term_ext;

    // Representable in WIDTH signed bits iff everything above the sign bit matches it.
    assign sum_upper = acc_sum[ACC_W-1:WIDTH-1];
    assign sum_ovf   = !((&sum_upper) || !(|sum_upper));

`ifdef VECTOR_DOT_SAT_EN
    assign sum_res = sum_ovf ? (acc_sum[ACC_W-1] ? fixed_point::FP_MIN : fixed_point::FP_MAX)
                             : acc_sum[WIDTH-1:0];
`else
    assign sum_res = acc_sum[WIDTH-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            acc       <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op1_q    <= op1;
                        op2_q    <= op2;
                        acc      <= '0;
                        in_ready <= 1'b0;
                        state    <= MUL_X;
                    end
                end
                MUL_X: begin
                    acc   <= acc_sum;
                    state <= MUL_Y;
                end
                MUL_Y: begin
                    acc   <= acc_sum;
                    state <= MUL_Z;
                end
                MUL_Z: begin
                    acc       <= acc_sum;
                    result    <= sum_res;
                    overflow  <= sum_ovf;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    // in_ready returns only after the output handshake edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
